// File: rtl/rsfq_clocked_gate_n.sv
// rsfq_clocked_gate_n: cycle-based model of an N-input clocked RSFQ gate.
// Toggle-encoded input pulses are accumulated between readout pulses. Each
// readout evaluates OR / AND / XOR / threshold over the window, toggles q one
// cycle later on a fire, and clears the window. Hold-time violations between
// a channel pulse and the following readout are flagged in sticky registers.
//
// Handshake note: there is no valid/ready pairing here. Every transition on
// in_tgl / rd_tgl is one pulse, q_pulse is a one-cycle strobe that marks the
// cycle q toggles, and ready only says the begin window has elapsed.
module rsfq_clocked_gate_n #(
    parameter int N         = 4,
    parameter int MODE      = 0,
    parameter int THRESH    = 2,
    parameter int HOLD_CYC  = 2,
    parameter int BEGIN_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_tgl,
    input  logic             rd_tgl,
    output logic             q,
    output logic             q_pulse,
    output logic             ready,
    output logic             viol,
    output logic [N-1:0]     viol_mask,
    output logic [CNT_W-1:0] fire_cnt
);

    localparam int AW = $clog2(HOLD_CYC + 1);
    localparam int BW = $clog2(BEGIN_CYC + 1);
    localparam int PW = $clog2(N + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    begin_cnt_q, begin_cnt_d;
    logic [N-1:0]     in_prev_q, in_prev_d;
    logic             rd_prev_q, rd_prev_d;
    logic [N-1:0]     arr_q, arr_d;
    logic [N-1:0]     par_q, par_d;
    logic [AW-1:0]    age_q [N];
    logic [AW-1:0]    age_d [N];
    logic             fire_q, fire_d;
    logic             q_q, q_d;
    logic             q_pulse_q, q_pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol_q, viol_d;
    logic [N-1:0]     vmask_q, vmask_d;

    logic [N-1:0]     in_p;
    logic             rd_p;
    logic [N-1:0]     eff_arr;
    logic [N-1:0]     eff_par;
    logic [PW-1:0]    pop;
    logic             fire_now;
    logic [N-1:0]     hold_hit;

    // Pulse detection and the effective window contents including this cycle's pulses.
    always_comb begin
        in_p    = in_tgl ^ in_prev_q;
        rd_p    = rd_tgl ^ rd_prev_q;
        eff_arr = arr_q | in_p;
        eff_par = par_q ^ in_p;
    end

    // Evaluate the selected function and the hold check over the effective window.
    always_comb begin
        pop      = '0;
        hold_hit = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(eff_arr[i]);
            // age_q is 0 right after the pulse edge, so the cycles elapsed
            // at this edge are age_q + 1; a same-cycle pulse has elapsed 0.
            if (eff_arr[i] && (in_p[i] || (int'(age_q[i]) + 1 < HOLD_CYC))) begin
                hold_hit[i] = 1'b1;
            end
        end
        if (MODE == 0) begin
            fire_now = |eff_arr;
        end else if (MODE == 1) begin
            fire_now = &eff_arr;
        end else if (MODE == 2) begin
            fire_now = ^eff_par;
        end else if (MODE == 3) begin
            fire_now = (int'(pop) >= THRESH);
        end else begin
            fire_now = 1'b0;
        end
    end

    // State machine: INIT counts out the begin window, then RUN forever until reset.
    always_comb begin
        state_d     = state_q;
        begin_cnt_d = begin_cnt_q;
        case (state_q)
            ST_INIT: begin
                begin_cnt_d = begin_cnt_q + BW'(1);
                if (int'(begin_cnt_q) >= BEGIN_CYC - 1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Window accumulation, channel ages, hold flags and the registered fire decision.
    always_comb begin
        in_prev_d = in_tgl;
        rd_prev_d = rd_tgl;
        arr_d     = arr_q;
        par_d     = par_q;
        fire_d    = 1'b0;
        viol_d    = viol_q;
        vmask_d   = vmask_q;
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
        end
        if (state_q == ST_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (in_p[i]) begin
                    age_d[i] = '0;
                end else if (int'(age_q[i]) < HOLD_CYC) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
            if (rd_p) begin
                fire_d  = fire_now;
                vmask_d = vmask_q | hold_hit;
                viol_d  = viol_q | (|hold_hit);
                arr_d   = '0;
                par_d   = '0;
            end else begin
                arr_d = eff_arr;
                par_d = eff_par;
            end
        end
    end

    // Output stage: a fire decided at edge k shows up on q after edge k+1.
    always_comb begin
        q_d       = q_q ^ fire_q;
        q_pulse_d = fire_q;
        cnt_d     = fire_q ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            begin_cnt_q <= '0;
            in_prev_q   <= '0;
            rd_prev_q   <= 1'b0;
            arr_q       <= '0;
            par_q       <= '0;
            fire_q      <= 1'b0;
            q_q         <= 1'b0;
            q_pulse_q   <= 1'b0;
            cnt_q       <= '0;
            viol_q      <= 1'b0;
            vmask_q     <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            begin_cnt_q <= begin_cnt_d;
            in_prev_q   <= in_prev_d;
            rd_prev_q   <= rd_prev_d;
            arr_q       <= arr_d;
            par_q       <= par_d;
            fire_q      <= fire_d;
            q_q         <= q_d;
            q_pulse_q   <= q_pulse_d;
            cnt_q       <= cnt_d;
            viol_q      <= viol_d;
            vmask_q     <= vmask_d;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign q         = q_q;
    assign q_pulse   = q_pulse_q;
    assign ready     = (state_q == ST_RUN);
    assign viol      = viol_q;
    assign viol_mask = vmask_q;
    assign fire_cnt  = cnt_q;

endmodule

// File: tb/tb_rsfq_clocked_gate_n.sv
// Bench for rsfq_clocked_gate_n: four N=4 instances (MODE 0..3) plus a MODE 0
// instance with a 4-bit counter share the same pulse stimulus. A window-level
// model predicts fires, which are queued and matched by a negedge monitor.
module tb_rsfq_clocked_gate_n;
  localparam int N   = 4;
  localparam int HLD = 2;
  localparam int BEG = 8;
  localparam int THR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in_tgl = '0;
  logic rd_tgl = 1'b0;

  logic [4:0] q_w, qp_w, rdy_w, viol_w;
  logic [19:0] vm_all;
  logic [15:0] cnt_a [5];
  logic [3:0] cnt4;

  int edge_n = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int since_rel;
  logic [N-1:0] win_mask;
  int win_cnt [N];
  int last_p [N];
  logic [N-1:0] exp_vmask;
  int fc [5];
  logic [48:0] exp_q [5][$];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  rsfq_clocked_gate_n #(.N(N), .MODE(0), .THRESH(THR), .HOLD_CYC(HLD), .BEGIN_CYC(BEG), .CNT_W(16)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .rd_tgl(rd_tgl), .q(q_w[0]), .q_pulse(qp_w[0]),
    .ready(rdy_w[0]), .viol(viol_w[0]), .viol_mask(vm_all[3:0]), .fire_cnt(cnt_a[0]));
  rsfq_clocked_gate_n #(.N(N), .MODE(1), .THRESH(THR), .HOLD_CYC(HLD), .BEGIN_CYC(BEG), .CNT_W(16)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .rd_tgl(rd_tgl), .q(q_w[1]), .q_pulse(qp_w[1]),
    .ready(rdy_w[1]), .viol(viol_w[1]), .viol_mask(vm_all[7:4]), .fire_cnt(cnt_a[1]));
  rsfq_clocked_gate_n #(.N(N), .MODE(2), .THRESH(THR), .HOLD_CYC(HLD), .BEGIN_CYC(BEG), .CNT_W(16)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .rd_tgl(rd_tgl), .q(q_w[2]), .q_pulse(qp_w[2]),
    .ready(rdy_w[2]), .viol(viol_w[2]), .viol_mask(vm_all[11:8]), .fire_cnt(cnt_a[2]));
  rsfq_clocked_gate_n #(.N(N), .MODE(3), .THRESH(THR), .HOLD_CYC(HLD), .BEGIN_CYC(BEG), .CNT_W(16)) u_m3 (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .rd_tgl(rd_tgl), .q(q_w[3]), .q_pulse(qp_w[3]),
    .ready(rdy_w[3]), .viol(viol_w[3]), .viol_mask(vm_all[15:12]), .fire_cnt(cnt_a[3]));
  rsfq_clocked_gate_n #(.N(N), .MODE(0), .THRESH(THR), .HOLD_CYC(HLD), .BEGIN_CYC(BEG), .CNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .rd_tgl(rd_tgl), .q(q_w[4]), .q_pulse(qp_w[4]),
    .ready(rdy_w[4]), .viol(viol_w[4]), .viol_mask(vm_all[19:16]), .fire_cnt(cnt4));
  assign cnt_a[4] = {12'd0, cnt4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    since_rel = 0;
    win_mask  = '0;
    exp_vmask = '0;
    for (int i = 0; i < N; i++) begin
      win_cnt[i] = 0;
      last_p[i]  = 0;
    end
    for (int k = 0; k < 5; k++) fc[k] = 0;
  endtask

  // driver: one call = one sample edge; m = channels pulsed, r = readout pulse
  task automatic step(input logic [N-1:0] m, input logic r);
    int e;
    int tot;
    int md;
    int cv;
    bit f [4];
    in_tgl = in_tgl ^ m;
    rd_tgl = rd_tgl ^ r;
    e = edge_n + 1;
    since_rel++;
    if (since_rel > BEG) begin
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          win_mask[i] = 1'b1;
          win_cnt[i]++;
          last_p[i] = e;
        end
      end
      if (r) begin
        tot = 0;
        for (int i = 0; i < N; i++) begin
          tot += win_cnt[i];
          if (win_mask[i] && (e - last_p[i] < HLD)) exp_vmask[i] = 1'b1;
        end
        f[0] = (win_mask != 0);
        f[1] = (win_mask == {N{1'b1}});
        f[2] = (tot % 2 == 1);
        f[3] = ($countones(win_mask) >= THR);
        for (int k = 0; k < 5; k++) begin
          md = (k == 4) ? 0 : k;
          if (f[md]) begin
            fc[k]++;
            cv = (k == 4) ? fc[k] % 16 : fc[k] % 65536;
            exp_q[k].push_back({32'(e + 1), 1'(fc[k] % 2), 16'(cv)});
          end
        end
        win_mask = '0;
        for (int i = 0; i < N; i++) win_cnt[i] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ready[%0d]", k), 32'(rdy_w[k]), 32'(since_rel >= BEG));
      chk($sformatf("viol_mask[%0d]", k), 32'(vm_all[k*4 +: 4]), 32'(exp_vmask));
      chk($sformatf("viol[%0d]", k), 32'(viol_w[k]), 32'(exp_vmask != 0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_q[%0d]", k), 32'(q_w[k]), 32'd0);
      chk($sformatf("rst_qp[%0d]", k), 32'(qp_w[k]), 32'd0);
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy_w[k]), 32'd0);
      chk($sformatf("rst_viol[%0d]", k), 32'(viol_w[k]), 32'd0);
      chk($sformatf("rst_vmask[%0d]", k), 32'(vm_all[k*4 +: 4]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", k), 32'(cnt_a[k]), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  // scoreboard monitor: every q_pulse must match the oldest expected fire
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (exp_q[k].size() > 0 && int'(exp_q[k][0][48:17]) < edge_n) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fire_missing[%0d]: no q_pulse, wanted at edge %0d (now %0d)",
                 k, exp_q[k][0][48:17], edge_n);
        void'(exp_q[k].pop_front());
      end
      if (qp_w[k]) begin
        if (exp_q[k].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL fire_spurious[%0d]: q_pulse at edge %0d, wanted none", k, edge_n);
        end else begin
          logic [48:0] t;
          t = exp_q[k].pop_front();
          chk($sformatf("fire_edge[%0d]", k), 32'(edge_n), t[48:17]);
          chk($sformatf("fire_q[%0d]", k), 32'(q_w[k]), 32'(t[16]));
          chk($sformatf("fire_cnt[%0d]", k), 32'(cnt_a[k]), 32'(t[15:0]));
        end
      end
    end
  end

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // begin window: pulse at cycle 3, readout at cycle 5, readout at cycle 10
    idle(2);
    step(4'b0001, 1'b0);
    idle(1);
    step('0, 1'b1);
    idle(4);
    step('0, 1'b1);
    idle(2);

    // OR basics, then an empty readout
    step(4'b0100, 1'b0);
    idle(3);
    step('0, 1'b1);
    idle(2);
    chk("or_cnt", 32'(cnt_a[0]), 32'd1);
    step('0, 1'b1);
    idle(2);

    // mode patterns (all instances see every window)
    step(4'b0111, 1'b0); idle(3); step('0, 1'b1); idle(2);
    step(4'b1111, 1'b0); idle(3); step('0, 1'b1); idle(2);
    step(4'b0010, 1'b0); step(4'b0010, 1'b0); idle(3); step('0, 1'b1); idle(2);
    step(4'b1010, 1'b0); idle(3); step('0, 1'b1); idle(2);
    step(4'b0001, 1'b0); step(4'b0011, 1'b0); idle(3); step('0, 1'b1); idle(2);

    // hold violation one cycle before readout, then clean readouts
    step(4'b0010, 1'b0);
    step('0, 1'b1);
    idle(2);
    chk("hold_vmask", 32'(vm_all[3:0]), 32'h2);
    step(4'b0001, 1'b0); idle(3); step('0, 1'b1); idle(2);
    step('0, 1'b1); idle(2);
    chk("hold_sticky", 32'(vm_all[3:0]), 32'h2);

    // pulse in the same cycle as the readout, then an empty readout
    step(4'b1000, 1'b1);
    idle(2);
    step('0, 1'b1);
    idle(2);
    chk("simul_vmask", 32'(vm_all[3:0]), 32'ha);

    // reset mid-operation
    step(4'b0001, 1'b0);
    idle(1);
    do_reset();
    idle(BEG);
    step('0, 1'b1);
    idle(2);

    // counter wrap: 17 fires
    for (int n = 0; n < 17; n++) begin
      step(4'b0001, 1'b0);
      idle(2);
      step('0, 1'b1);
    end
    idle(2);
    chk("wrap_cnt4", 32'(cnt_a[4]), 32'd1);
    chk("wrap_cnt16", 32'(cnt_a[0]), 32'd17);

    // randomized traffic including back-to-back readouts
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] m;
      logic r;
      m = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      r = ($urandom_range(0, 2) == 0);
      step(m, r);
    end
    idle(3);
    for (int k = 0; k < 5; k++) chk($sformatf("queue_empty[%0d]", k), 32'(exp_q[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
